// File: rtl/cgra_dmem_responder.sv
// Shared single-port data memory for CGRA tiles: round-robin store/load arbitration, one access
// per cycle, fully pipelined load responses returned two cycles after acceptance on per-tile lanes.
module cgra_dmem_responder #(
   parameter int NUM_TILES = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int REG_W     = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_TILES-1:0]        req_valid_i,
   input  logic [NUM_TILES-1:0]        req_we_i,
   input  logic [NUM_TILES*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_TILES*DATA_W-1:0] req_wdata_i,
   input  logic [NUM_TILES*REG_W-1:0]  req_reg_i,
   output logic [NUM_TILES-1:0]        req_ready_o,
   output logic [NUM_TILES-1:0]        rsp_valid_o,
   output logic [NUM_TILES*DATA_W-1:0] rsp_data_o,
   output logic [NUM_TILES*REG_W-1:0]  rsp_reg_o
);

   localparam int               IDX_W    = $clog2(NUM_TILES);
   localparam int               MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [IDX_W-1:0]            cand, grant_idx;
   logic                        grant_found, accept;
   logic                        g_we, g_in_range;
   logic [ADDR_W-1:0]           g_addr;
   logic [DATA_W-1:0]           g_wdata;
   logic [REG_W-1:0]            g_reg;

   logic                        s1_valid_q, s1_valid_d;
   logic [IDX_W-1:0]            s1_tile_q, s1_tile_d;
   logic [ADDR_W-1:0]           s1_addr_q, s1_addr_d;
   logic [REG_W-1:0]            s1_reg_q, s1_reg_d;
   logic                        s1_in_range;
   logic [DATA_W-1:0]           rd_data;

   logic [NUM_TILES-1:0]        rsp_valid_q, rsp_valid_d;
   logic [NUM_TILES*DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [NUM_TILES*REG_W-1:0]  rsp_reg_q, rsp_reg_d;

   logic [DATA_W-1:0]           mem [DEPTH];

   // Round-robin search from ptr_q; the first valid tile in wrap order wins.
   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_TILES; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % NUM_TILES);
         if (!grant_found && req_valid_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign accept     = grant_found & ~rst_i;
   assign g_we       = req_we_i[grant_idx];
   assign g_addr     = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
   assign g_wdata    = req_wdata_i[grant_idx*DATA_W +: DATA_W];
   assign g_reg      = req_reg_i[grant_idx*REG_W +: REG_W];
   assign g_in_range = {1'b0, g_addr} < DEPTH_L;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[grant_idx] = 1'b1;
   end

   // NOTE: the SRAM array has no reset branch; contents survive rst_i, as a real macro would.
   // NOTE: state is updated with non-blocking assignments so same-edge reads see the old value.
   always_ff @(posedge clk_i) begin
      if (accept && g_we && g_in_range) mem[g_addr[MEM_AW-1:0]] <= g_wdata;
   end

   // A store accepted one cycle earlier is already in the array when S1 reads it.
   assign s1_in_range = {1'b0, s1_addr_q} < DEPTH_L;
   assign rd_data     = s1_in_range ? mem[s1_addr_q[MEM_AW-1:0]] : '0;

   always_comb begin
      ptr_d      = ptr_q;
      s1_valid_d = accept & ~g_we;
      s1_tile_d  = s1_tile_q;
      s1_addr_d  = s1_addr_q;
      s1_reg_d   = s1_reg_q;
      if (accept) begin
         ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
         s1_tile_d = grant_idx;
         s1_addr_d = g_addr;
         s1_reg_d  = g_reg;
      end

      // Lanes not strobed this cycle keep their last response.
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_reg_d   = rsp_reg_q;
      if (s1_valid_q) begin
         rsp_valid_d[s1_tile_q]                 = 1'b1;
         rsp_data_d[s1_tile_q*DATA_W +: DATA_W] = rd_data;
         rsp_reg_d[s1_tile_q*REG_W +: REG_W]    = s1_reg_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_tile_q   <= '0;
         s1_addr_q   <= '0;
         s1_reg_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_reg_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_tile_q   <= s1_tile_d;
         s1_addr_q   <= s1_addr_d;
         s1_reg_q    <= s1_reg_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_reg_q   <= rsp_reg_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_reg_o   = rsp_reg_q;

endmodule

// File: tb/tb_cgra_dmem_responder.sv
// Directed bench for cgra_dmem_responder: a DEPTH=1024 and a DEPTH=512 instance share stimulus;
// each has its own memory model and response scoreboard checked every cycle.
module tb_cgra_dmem_responder;

   localparam int NT      = 4;
   localparam int DW      = 32;
   localparam int AW      = 10;
   localparam int RW      = 3;
   localparam int DEPTH_B = 1024;
   localparam int DEPTH_S = 512;

   typedef struct {
      int            due;
      int            tile;
      logic [DW-1:0] data;
      logic [RW-1:0] rg;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NT-1:0] req_valid, req_we;
   logic [NT*AW-1:0] req_addr;
   logic [NT*DW-1:0] req_wdata;
   logic [NT*RW-1:0] req_reg;
   logic [NT-1:0] ready_b, ready_s, rvalid_b, rvalid_s;
   logic [NT*DW-1:0] rdata_b, rdata_s;
   logic [NT*RW-1:0] rreg_b, rreg_s;

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   rsp_t          sb_b[$];
   rsp_t          sb_s[$];
   logic [DW-1:0] mem_b [DEPTH_B];
   logic [DW-1:0] mem_s [DEPTH_S];
   logic [NT*DW-1:0] lane_data [2];
   logic [NT*RW-1:0] lane_reg [2];

   cgra_dmem_responder #(
      .NUM_TILES(NT), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_B), .REG_W(RW)
   ) u_big (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_reg_i(req_reg), .req_ready_o(ready_b),
      .rsp_valid_o(rvalid_b), .rsp_data_o(rdata_b), .rsp_reg_o(rreg_b)
   );

   cgra_dmem_responder #(
      .NUM_TILES(NT), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH_S), .REG_W(RW)
   ) u_small (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .req_reg_i(req_reg), .req_ready_o(ready_s),
      .rsp_valid_o(rvalid_s), .rsp_data_o(rdata_s), .rsp_reg_o(rreg_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare strobes and every lane's held data/tag each cycle.
   task automatic mon_one(input int which, input logic [NT-1:0] v,
                          input logic [NT*DW-1:0] d, input logic [NT*RW-1:0] r);
      rsp_t          e;
      bit            have = 1'b0;
      logic [NT-1:0] ev   = '0;
      string         tag  = (which == 0) ? "d1024" : "d512";
      if (which == 0) begin
         if (sb_b.size() != 0 && sb_b[0].due == cyc) begin
            e = sb_b.pop_front();
            have = 1'b1;
         end
      end else begin
         if (sb_s.size() != 0 && sb_s[0].due == cyc) begin
            e = sb_s.pop_front();
            have = 1'b1;
         end
      end
      if (have) begin
         ev[e.tile] = 1'b1;
         lane_data[which][e.tile*DW +: DW] = e.data;
         lane_reg[which][e.tile*RW +: RW]  = e.rg;
      end
      check({tag, " rsp_valid"}, 128'(v), 128'(ev));
      check({tag, " rsp_data"}, 128'(d), 128'(lane_data[which]));
      check({tag, " rsp_reg"}, 128'(r), 128'(lane_reg[which]));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_one(0, rvalid_b, rdata_b, rreg_b);
         mon_one(1, rvalid_s, rdata_s, rreg_s);
      end
   end

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_reg   = '0;
   endtask

   task automatic set_req(input int t, input bit we, input int addr, input logic [DW-1:0] wd,
                          input int rg);
      req_valid[t]           = 1'b1;
      req_we[t]              = we;
      req_addr[t*AW +: AW]   = AW'(addr);
      req_wdata[t*DW +: DW]  = wd;
      req_reg[t*RW +: RW]    = RW'(rg);
   endtask

   // Stimulus side: apply an accepted request to the models and push expected responses.
   task automatic accept_model(input int t);
      int   a;
      rsp_t e;
      a = int'(req_addr[t*AW +: AW]);
      if (req_we[t]) begin
         if (a < DEPTH_B) mem_b[a] = req_wdata[t*DW +: DW];
         if (a < DEPTH_S) mem_s[a] = req_wdata[t*DW +: DW];
      end else begin
         e.due  = cyc + 2;
         e.tile = t;
         e.rg   = req_reg[t*RW +: RW];
         e.data = (a < DEPTH_B) ? mem_b[a] : '0;
         sb_b.push_back(e);
         e.data = (a < DEPTH_S) ? mem_s[a] : '0;
         sb_s.push_back(e);
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic tick(input logic [NT-1:0] exp_ready, input string tag);
      #1;
      check({tag, " ready d1024"}, 128'(ready_b), 128'(exp_ready));
      check({tag, " ready d512"}, 128'(ready_s), 128'(exp_ready));
      for (int t = 0; t < NT; t++) begin
         if (exp_ready[t]) accept_model(t);
      end
      @(posedge clk);
      if (rst) begin
         sb_b.delete();
         sb_s.delete();
         lane_data[0] = '0;
         lane_data[1] = '0;
         lane_reg[0]  = '0;
         lane_reg[1]  = '0;
      end
      mon_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic one(input int t, input bit we, input int addr, input logic [DW-1:0] wd,
                      input int rg, input string tag);
      clear_reqs();
      set_req(t, we, addr, wd, rg);
      tick(NT'(1) << t, tag);
   endtask

   task automatic idle(input int n);
      clear_reqs();
      repeat (n) tick('0, "idle");
   endtask

   initial begin
      logic [NT-1:0] ex;
      lane_data[0] = '0;
      lane_data[1] = '0;
      lane_reg[0]  = '0;
      lane_reg[1]  = '0;

      // Reset with a pending request: nothing granted.
      rst = 1'b1;
      clear_reqs();
      set_req(0, 1'b0, 5, '0, 1);
      tick('0, "rst_wins");
      rst = 1'b0;
      idle(1);

      // Store then load at the same address from tile 0.
      one(0, 1'b1, 5, 32'hDEAD_BEEF, 0, "t1 store");
      one(0, 1'b0, 5, '0, 3, "t1 load");
      idle(3);

      // Top-of-range and beyond-DEPTH accesses on both depths.
      one(2, 1'b1, 1023, 32'd7, 0, "t4 st1023");
      one(2, 1'b0, 1023, '0, 5, "t4 ld1023");
      one(1, 1'b1, 600, 32'h1234_5678, 0, "t4 st600");
      one(1, 1'b0, 600, '0, 6, "t4 ld600");
      one(3, 1'b1, 511, 32'hA5A5_A5A5, 0, "t4 st511");
      one(3, 1'b0, 511, '0, 7, "t4 ld511");
      idle(3);

      // Preload, reset, then all four tiles hold loads for eight cycles.
      for (int i = 0; i < NT; i++) one(3, 1'b1, 100 + i, 32'hA000_0000 + i, 0, "t2 preload");
      clear_reqs();
      rst = 1'b1;
      tick('0, "t2 rst");
      rst = 1'b0;
      for (int t = 0; t < NT; t++) set_req(t, 1'b0, 100 + t, '0, t);
      for (int k = 0; k < 8; k++) begin
         ex = NT'(1) << (k % NT);
         tick(ex, "t2 rr");
      end
      idle(3);

      // Pointer moved to 2, then only tiles 1 and 3 request.
      one(1, 1'b0, 101, '0, 2, "t3 setptr");
      clear_reqs();
      set_req(1, 1'b0, 101, '0, 1);
      set_req(3, 1'b0, 103, '0, 3);
      tick(4'b1000, "t3 g3a");
      tick(4'b0010, "t3 g1");
      tick(4'b1000, "t3 g3b");
      idle(3);

      // Load in flight dropped by reset; pointer back to 0; stored data survives.
      one(0, 1'b0, 5, '0, 2, "t5 load");
      clear_reqs();
      rst = 1'b1;
      set_req(1, 1'b0, 5, '0, 0);
      set_req(2, 1'b0, 5, '0, 0);
      tick('0, "t5 rst");
      rst = 1'b0;
      for (int t = 0; t < NT; t++) set_req(t, 1'b0, 5, '0, t);
      tick(4'b0001, "t5 ptr0");
      idle(3);

      // Back-to-back store/load/store/load on one address across tiles.
      one(1, 1'b1, 9, 32'd1, 0, "t6 st1");
      one(2, 1'b0, 9, '0, 4, "t6 ld1");
      one(3, 1'b1, 9, 32'd2, 0, "t6 st2");
      one(0, 1'b0, 9, '0, 5, "t6 ld2");
      idle(3);

      check("sb drain d1024", 128'(sb_b.size()), 128'(0));
      check("sb drain d512", 128'(sb_s.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
